// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: receive-side bundle between the UART receiver and the
// logic that consumes its output.
//   out_data   : last received data word, LSB = first bit on the line
//   out_flag   : one-cycle strobe when a frame completes
//   parity_err : parity mismatch on the frame, valid from out_flag onward
//   frame_err  : a stop bit was sampled low
//   break_det  : every data, parity and stop sample was low
//   rx_busy    : a frame is in progress
// modport master = receiver (drives), modport slave = consumer (reads).
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_flag;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 rx_busy;

    modport master (
        output out_data, out_flag, parity_err, frame_err, break_det, rx_busy
    );

    modport slave (
        input out_data, out_flag, parity_err, frame_err, break_det, rx_busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver. Supports 5..9 data bits, optional
// odd/even parity and one or two stop bits. Each bit is decided by a 2-of-3
// majority around mid-bit. False starts are rejected, and parity, framing
// and break errors are reported alongside a one-cycle strobe per frame.
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   rx      : asynchronous serial input, idles high
//   rx_out  : receive bundle (uart_rx_cfg_if.master)
//
// state    | meaning
// S_IDLE   | waiting for a synchronised 1->0 edge, bit timer held at 0
// S_START  | timing the start bit, majority 1 rejects it as a glitch
// S_DATA   | shifting in DATA_BITS bits, LSB first
// S_PARITY | checking the parity bit (only if PARITY != 0)
// S_STOP   | checking STOP_BITS stop bits, the frame is published at the
//          | last stop decision point
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 921600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            rx,
    uart_rx_cfg_if.master   rx_out
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);

    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(HALF - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(HALF);
    localparam logic [CW-1:0] DECIDE   = CW'(HALF + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 one_acc;
    logic                 ferr_acc;

    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_s3;
    logic [1:0]           fill;
    logic                 armed;

    logic                 start_edge;
    logic                 maj;
    logic                 at_decide;

    // The synchroniser resets to 1, so a line held low through reset would
    // look like a falling edge once real samples arrive. armed is only set
    // after a genuine high sample has propagated through, which blocks that
    // phantom edge (and any partial frame still on the wire after reset).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && rx_s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = armed & rx_s3 & ~rx_s2;
    assign maj        = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    assign at_decide  = (cnt == DECIDE);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            samp_a            <= 1'b1;
            samp_b            <= 1'b1;
            shreg             <= '0;
            par_acc           <= 1'b0;
            one_acc           <= 1'b0;
            ferr_acc          <= 1'b0;
            rx_out.out_data   <= '0;
            rx_out.out_flag   <= 1'b0;
            rx_out.parity_err <= 1'b0;
            rx_out.frame_err  <= 1'b0;
            rx_out.break_det  <= 1'b0;
            rx_out.rx_busy    <= 1'b0;
        end else begin
            rx_out.out_flag <= 1'b0;

            if (state == S_IDLE || cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (cnt == SAMP_A) begin
                samp_a <= rx_s2;
            end
            if (cnt == SAMP_B) begin
                samp_b <= rx_s2;
            end

            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state          <= S_START;
                        bit_idx        <= '0;
                        par_acc        <= 1'b0;
                        one_acc        <= 1'b0;
                        ferr_acc       <= 1'b0;
                        rx_out.rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (at_decide) begin
                        if (maj) begin
                            state          <= S_IDLE;
                            cnt            <= '0;
                            rx_out.rx_busy <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (at_decide) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ maj;
                        one_acc <= one_acc | maj;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end

                S_PARITY: begin
                    if (at_decide) begin
                        par_acc <= par_acc ^ maj;
                        one_acc <= one_acc | maj;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (at_decide) begin
                        if (bit_idx == STOP_LAST) begin
                            // Leave at the decision point rather than the end
                            // of the stop bit so a back-to-back start edge is
                            // already seen from IDLE.
                            state             <= S_IDLE;
                            cnt               <= '0;
                            rx_out.rx_busy    <= 1'b0;
                            rx_out.out_flag   <= 1'b1;
                            rx_out.out_data   <= shreg;
                            rx_out.frame_err  <= ferr_acc | ~maj;
                            rx_out.break_det  <= ~(one_acc | maj);
                            // par_acc holds XOR of data and parity bits:
                            // odd parity expects 1, even parity expects 0.
                            rx_out.parity_err <= (PARITY == 1) ? ~par_acc :
                                                 (PARITY == 2) ?  par_acc : 1'b0;
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            ferr_acc <= ferr_acc | ~maj;
                            one_acc  <= one_acc | maj;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds configurable data width, optional odd/even parity, one or two stop bits, 3-sample majority voting per bit, false-start rejection, and parity/framing/break error reporting. Sits between the board RX pin and the byte-consuming logic, for example a FIFO or command parser. Produces one single-cycle strobe per received frame.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- UART_BPS, 921600: baud rate. BPS_CNT = CLK_FREQ/UART_BPS (integer floor) must be at least 8.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial input; idle level is 1.
- out_data  out  DATA_BITS  last received data word, LSB = first bit received. Reset value 0.
- out_flag  out  1  one-cycle strobe when a frame completes. Reset value 0.
- parity_err  out  1  parity mismatch on the current frame. Valid with out_flag, held until the next out_flag. Reset value 0.
- frame_err  out  1  at least one stop bit sampled 0. Same validity as parity_err. Reset value 0.
- break_det  out  1  all data, parity and stop samples were 0. Same validity as parity_err. Reset value 0.
- rx_busy  out  1  high from start-edge detection until the return to IDLE. Reset value 0.

## Operation
- Synchronisation: rx passes through two flip-flops, plus a third register for edge detection. All three reset to 1. A start edge is the synchronised 1->0 transition. A line held low through reset never produces a start edge.
- Bit timer: HALF = BPS_CNT/2. The counter runs 0..BPS_CNT-1 and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- Sampling: the synchronised rx is sampled at cnt = HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority. The bit decision is taken at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a start edge; counter cleared.
- START: if the majority is 1, treat it as a false start. Return to IDLE with no strobe and no error change. If the majority is 0, continue to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY: compare the received bit against the computed parity. Odd parity means the XOR of data and parity bits is 1; even parity means it is 0.
- STOP: sample STOP_BITS bits. Any 0 sets frame_err for the frame.
- The FSM returns to IDLE at the decision point of the last stop bit, not at the end of that bit. A new start edge can then be accepted immediately, so back-to-back frames work.
- At the last stop decision: out_data, parity_err, frame_err and break_det are registered, and out_flag pulses on the next cycle.
- With PARITY = 0, parity_err stays 0.
- break_det implies frame_err.
- Start edges seen outside IDLE are ignored.

## Timing
- Start edge at synchronised-sample cycle T: the counter is 0 at T+1, and the start decision is taken at T+1+HALF+1.
- Bit k has its decision at T+1+k*BPS_CNT+HALF+1, where k = 0 is the start bit.
- Frame length N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- out_flag is high exactly one cycle, at T+2+(N-1)*BPS_CNT+HALF+1.
- Pin-to-strobe latency includes 2 extra synchroniser cycles.
- rx_busy falls in the same cycle out_flag rises. After a false start, rx_busy falls one cycle after the start decision.
- Reset asserted mid-frame: FSM goes to IDLE, all outputs go to their reset values, and the partial frame is discarded with no strobe. After release, reception resumes on the next 1->0 edge.
- Tolerated baud mismatch is at least ±3% with 8N1 at BPS_CNT ≥ 16.

## Test plan
- Default parameters (BPS_CNT = 54), send 0xA5 as 8N1 -> one out_flag pulse, out_data = 0xA5, parity_err = frame_err = break_det = 0, rx_busy low afterwards.
- PARITY = 2, DATA_BITS = 7, send 0x03 with parity bit 1 (even parity requires 0) -> out_data = 0x03, parity_err = 1. Then send 0x03 with parity bit 0 -> parity_err = 0.
- STOP_BITS = 2, send 0x5A with the second stop bit 0 -> out_data = 0x5A, frame_err = 1, break_det = 0. Then hold rx low for 12 bit times -> out_flag with out_data = 0, frame_err = 1, break_det = 1.
- Low glitch of 10 cycles on an idle line -> no out_flag, rx_busy high about 30 cycles then low. A following valid 0x3C is received correctly.
- Back-to-back 0x00 then 0xFF, 8N1, with the next start bit immediately after the stop bit -> two out_flag pulses, out_data 0x00 then 0xFF, no errors. Repeat with a single-cycle spike at the mid-sample of one data bit -> the value is unchanged by majority voting.
- Assert sys_rst during data bit 4 of 0x81 -> all outputs are 0 at once and no out_flag. After release, a fresh 0x81 is received with out_data = 0x81.
